// File: rtl/match_controller.sv
// match_controller: match FSM, countdown timer, scores and ball gating.
// Optional overtime state is enabled by defining MATCH_CONTROLLER_OVERTIME_EN.
//
// Ports:
//   clk, rst (async, active-high)
//   btn_n[NUM_BUTTONS] : active-low start buttons (pre-synchronised)
//   blue_goal, red_goal : single-cycle goal pulses from the ball controller
//   state       : 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVERTIME, 4 OVER
//   time_left   : seconds remaining
//   blue_score, red_score : saturating team scores
//   ball_enable : ball may move
//   ball_reset  : one-cycle re-serve pulse
//   game_over   : high in OVER
//   winner      : 0 none/draw, 1 blue, 2 red (valid with game_over)
// All outputs are registered.

module match_controller #(
  parameter int CLK_HZ            = 50000000,
  parameter int MATCH_SECONDS     = 180,
  parameter int TIME_WIDTH        = 8,
  parameter int NUM_BUTTONS       = 8,
  parameter int SCORE_WIDTH       = 7,
  parameter int WIN_SCORE         = 0,
  parameter int GOAL_PAUSE_CYCLES = 100000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] btn_n,
  input  logic                   blue_goal,
  input  logic                   red_goal,
  output logic [2:0]             state,
  output logic [TIME_WIDTH-1:0]  time_left,
  output logic [SCORE_WIDTH-1:0] blue_score,
  output logic [SCORE_WIDTH-1:0] red_score,
  output logic                   ball_enable,
  output logic                   ball_reset,
  output logic                   game_over,
  output logic [1:0]             winner
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int CW = (GOAL_PAUSE_CYCLES > 1) ?
                      $clog2(GOAL_PAUSE_CYCLES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_OT    = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_BLUE = 2'd1;
  localparam logic [1:0] W_RED  = 2'd2;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [CW-1:0] PAUSE_LAST =
    CW'(GOAL_PAUSE_CYCLES - 1);
  localparam logic [TIME_WIDTH-1:0] TIME_INIT =
    TIME_WIDTH'(MATCH_SECONDS);
  localparam logic [TIME_WIDTH-1:0] TIME_ONE = TIME_WIDTH'(1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_WIDTH-1:0] SCORE_ONE = SCORE_WIDTH'(1);

  // One extra bit so a WIN_SCORE above the saturation value
  // is never reached instead of aliasing to a small score.
  localparam logic [SCORE_WIDTH:0] WIN_TGT =
    (SCORE_WIDTH + 1)'(WIN_SCORE);
  localparam logic WIN_ON = (WIN_SCORE != 0);

  // Registered state
  logic [2:0]             state_q, state_d;
  logic [TIME_WIDTH-1:0]  time_q, time_d;
  logic [SCORE_WIDTH-1:0] blue_q, blue_d;
  logic [SCORE_WIDTH-1:0] red_q, red_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [CW-1:0]          pause_q, pause_d;
  logic                   ball_enable_q, ball_enable_d;
  logic                   ball_reset_q, ball_reset_d;
  logic                   game_over_q, game_over_d;
  logic [1:0]             winner_q, winner_d;

  // Shared combinational terms
  logic                   start;
  logic                   tick;
  logic                   final_tick;
  logic                   goal_any;
  logic [SCORE_WIDTH-1:0] blue_inc, red_inc;
  logic [SCORE_WIDTH-1:0] blue_nx, red_nx;
  logic                   blue_win, red_win, win_any;
  logic [1:0]             win_code;
  logic [1:0]             expiry_code;

  assign start      = ~(&btn_n);
  assign tick       = (presc_q == PRESC_LAST);
  assign final_tick = tick && (time_q == TIME_ONE);
  assign goal_any   = blue_goal || red_goal;

  assign blue_inc = (blue_q == SCORE_MAX) ?
                    blue_q : blue_q + SCORE_ONE;
  assign red_inc  = (red_q == SCORE_MAX) ?
                    red_q : red_q + SCORE_ONE;

  // Scores after this cycle's goals, used by both the
  // win check and the expiry comparison.
  assign blue_nx = blue_goal ? blue_inc : blue_q;
  assign red_nx  = red_goal ? red_inc : red_q;

  assign blue_win = WIN_ON && blue_goal &&
                    ({1'b0, blue_nx} >= WIN_TGT);
  assign red_win  = WIN_ON && red_goal &&
                    ({1'b0, red_nx} >= WIN_TGT);
  assign win_any  = blue_win || red_win;

  always_comb begin
    win_code = W_NONE;
    if (blue_win && !red_win) win_code = W_BLUE;
    if (red_win && !blue_win) win_code = W_RED;
  end

  always_comb begin
    expiry_code = W_NONE;
    if (blue_nx > red_nx) expiry_code = W_BLUE;
    if (red_nx > blue_nx) expiry_code = W_RED;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      time_q        <= TIME_INIT;
      blue_q        <= '0;
      red_q         <= '0;
      presc_q       <= '0;
      pause_q       <= '0;
      ball_enable_q <= 1'b0;
      ball_reset_q  <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= W_NONE;
    end else begin
      state_q       <= state_d;
      time_q        <= time_d;
      blue_q        <= blue_d;
      red_q         <= red_d;
      presc_q       <= presc_d;
      pause_q       <= pause_d;
      ball_enable_q <= ball_enable_d;
      ball_reset_q  <= ball_reset_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    time_d       = time_q;
    blue_d       = blue_q;
    red_d        = red_q;
    presc_d      = presc_q;
    pause_d      = pause_q;
    winner_d     = winner_q;
    ball_reset_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_PLAY;
          presc_d      = '0;
          ball_reset_d = 1'b1;
        end
      end

      S_PLAY: begin
        blue_d = blue_nx;
        red_d  = red_nx;
        if (win_any) begin
          state_d  = S_OVER;
          winner_d = win_code;
        end else if (final_tick) begin
          // Goal already folded into the scores above,
          // so expiry sees the updated totals.
          time_d  = '0;
          presc_d = '0;
          if (expiry_code != W_NONE) begin
            state_d  = S_OVER;
            winner_d = expiry_code;
          end else begin
`ifdef MATCH_CONTROLLER_OVERTIME_EN
            state_d  = S_OT;
`else
            state_d  = S_OVER;
`endif
            winner_d = W_NONE;
          end
        end else if (goal_any) begin
          // Timer and prescaler hold their value through
          // the pause, including a tick that lands here.
          state_d = S_PAUSE;
          pause_d = '0;
        end else if (tick) begin
          presc_d = '0;
          if (time_q != '0) time_d = time_q - TIME_ONE;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      S_PAUSE: begin
        if (pause_q == PAUSE_LAST) begin
          state_d      = S_PLAY;
          pause_d      = '0;
          ball_reset_d = 1'b1;
        end else begin
          pause_d = pause_q + CW'(1);
        end
      end

      S_OT: begin
`ifdef MATCH_CONTROLLER_OVERTIME_EN
        blue_d = blue_nx;
        red_d  = red_nx;
        if (win_any) begin
          state_d  = S_OVER;
          winner_d = win_code;
        end else if (blue_goal && red_goal) begin
          // Double goal keeps the tie; re-serve.
          ball_reset_d = 1'b1;
        end else if (blue_goal) begin
          state_d  = S_OVER;
          winner_d = W_BLUE;
        end else if (red_goal) begin
          state_d  = S_OVER;
          winner_d = W_RED;
        end
`else
        state_d = S_IDLE;
`endif
      end

      S_OVER: begin
        state_d = S_OVER;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic, registered alongside the state
  always_comb begin
    ball_enable_d = (state_d == S_PLAY) ||
                    (state_d == S_OT);
    game_over_d   = (state_d == S_OVER);
  end

  assign state       = state_q;
  assign time_left   = time_q;
  assign blue_score  = blue_q;
  assign red_score   = red_q;
  assign ball_enable = ball_enable_q;
  assign ball_reset  = ball_reset_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed bench for match_controller.
// Small timing parameters; immediate assertions at each check.

module tb_match_controller;

  localparam int CLK_HZ = 10;
  localparam int MS     = 3;
  localparam int TW     = 8;
  localparam int NB     = 8;
  localparam int SW     = 7;
  localparam int WS     = 2;
  localparam int GP     = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_n = '1;
  logic          blue_goal = 1'b0;
  logic          red_goal = 1'b0;
  logic [2:0]    state;
  logic [TW-1:0] time_left;
  logic [SW-1:0] blue_score;
  logic [SW-1:0] red_score;
  logic          ball_enable;
  logic          ball_reset;
  logic          game_over;
  logic [1:0]    winner;

  int checks = 0;
  int failures = 0;

  match_controller #(
    .CLK_HZ(CLK_HZ),
    .MATCH_SECONDS(MS),
    .TIME_WIDTH(TW),
    .NUM_BUTTONS(NB),
    .SCORE_WIDTH(SW),
    .WIN_SCORE(WS),
    .GOAL_PAUSE_CYCLES(GP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .blue_goal(blue_goal),
    .red_goal(red_goal),
    .state(state),
    .time_left(time_left),
    .blue_score(blue_score),
    .red_score(red_score),
    .ball_enable(ball_enable),
    .ball_reset(ball_reset),
    .game_over(game_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int obs,
                       input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn_n[5] = 1'b0;
    tick(1);
    btn_n = '1;
  endtask

  task automatic goal(input logic b, input logic r);
    blue_goal = b;
    red_goal  = r;
    tick(1);
    blue_goal = 1'b0;
    red_goal  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic check_rst_vals(input string tag);
    check({tag, ".state"}, 32'(state), 0);
    check({tag, ".time"}, 32'(time_left), MS);
    check({tag, ".blue"}, 32'(blue_score), 0);
    check({tag, ".red"}, 32'(red_score), 0);
    check({tag, ".ben"}, 32'(ball_enable), 0);
    check({tag, ".brst"}, 32'(ball_reset), 0);
    check({tag, ".gover"}, 32'(game_over), 0);
    check({tag, ".win"}, 32'(winner), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset
    tick(2);
    check_rst_vals("por");
    rst = 1'b0;
    tick(1);

    // Goals ignored in IDLE
    goal(1'b1, 1'b1);
    check("idle_goal.state", 32'(state), 0);
    check("idle_goal.blue", 32'(blue_score), 0);
    check("idle_goal.red", 32'(red_score), 0);

    // Start and full countdown at 0-0
    press();
    check("start.state", 32'(state), 1);
    check("start.brst", 32'(ball_reset), 1);
    check("start.ben", 32'(ball_enable), 1);
    check("start.time", 32'(time_left), 3);
    tick(1);
    check("start.brst_off", 32'(ball_reset), 0);
    tick(8);
    check("cd.t9", 32'(time_left), 3);
    tick(1);
    check("cd.t10", 32'(time_left), 2);
    tick(10);
    check("cd.t20", 32'(time_left), 1);
    tick(10);
    check("cd.t30", 32'(time_left), 0);
`ifdef MATCH_CONTROLLER_OVERTIME_EN
    check("ot.state", 32'(state), 3);
    check("ot.ben", 32'(ball_enable), 1);
    tick(3);
    check("ot.time", 32'(time_left), 0);
    goal(1'b0, 1'b1);
    check("ot_goal.state", 32'(state), 4);
    check("ot_goal.win", 32'(winner), 2);
    check("ot_goal.red", 32'(red_score), 1);
    check("ot_goal.gover", 32'(game_over), 1);
`else
    check("exp.state", 32'(state), 4);
    check("exp.win", 32'(winner), 0);
    check("exp.gover", 32'(game_over), 1);
    check("exp.ben", 32'(ball_enable), 0);
`endif
    press();
    check("over_btn.state", 32'(state), 4);
    check("over_btn.time", 32'(time_left), 0);

    // Goal pause with frozen timer, then win by score
    do_reset();
    press();
    tick(6);
    goal(1'b1, 1'b0);
    check("gp.state", 32'(state), 2);
    check("gp.blue", 32'(blue_score), 1);
    check("gp.ben", 32'(ball_enable), 0);
    goal(1'b0, 1'b1);
    check("gp.red_ign", 32'(red_score), 0);
    check("gp.state2", 32'(state), 2);
    tick(2);
    check("gp.state4", 32'(state), 2);
    check("gp.time", 32'(time_left), 3);
    tick(1);
    check("gp.resume", 32'(state), 1);
    check("gp.brst", 32'(ball_reset), 1);
    check("gp.ben_on", 32'(ball_enable), 1);
    tick(3);
    check("gp.presc_hold", 32'(time_left), 3);
    tick(1);
    check("gp.presc_wrap", 32'(time_left), 2);
    goal(1'b1, 1'b0);
    check("win.state", 32'(state), 4);
    check("win.blue", 32'(blue_score), 2);
    check("win.win", 32'(winner), 1);
    check("win.brst", 32'(ball_reset), 0);
    goal(1'b0, 1'b1);
    check("win.red_ign", 32'(red_score), 0);
    check("win.hold", 32'(winner), 1);

    // Double goal at 1-1: both reach WIN_SCORE -> draw
    do_reset();
    press();
    tick(2);
    goal(1'b1, 1'b0);
    tick(4);
    check("dbl.resume1", 32'(state), 1);
    goal(1'b0, 1'b1);
    check("dbl.pause2", 32'(state), 2);
    tick(4);
    check("dbl.resume2", 32'(state), 1);
    goal(1'b1, 1'b1);
    check("dbl.blue", 32'(blue_score), 2);
    check("dbl.red", 32'(red_score), 2);
    check("dbl.state", 32'(state), 4);
    check("dbl.win", 32'(winner), 0);

    // Red goal on the final tick at 0-0
    do_reset();
    press();
    tick(29);
    check("ft.pre_time", 32'(time_left), 1);
    check("ft.pre_state", 32'(state), 1);
    goal(1'b0, 1'b1);
    check("ft.red", 32'(red_score), 1);
    check("ft.state", 32'(state), 4);
    check("ft.win", 32'(winner), 2);
    check("ft.time", 32'(time_left), 0);

    // Asynchronous reset in the middle of PAUSE
    do_reset();
    press();
    tick(2);
    goal(1'b1, 1'b0);
    check("ar.pause", 32'(state), 2);
    #3;
    rst = 1'b1;
    #1;
    check_rst_vals("ar");
    #1;
    rst = 1'b0;
    tick(1);
    check("ar.idle", 32'(state), 0);
    press();
    check("ar.restart", 32'(state), 1);
    check("ar.time", 32'(time_left), 3);
    check("ar.brst", 32'(ball_reset), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Parametrised successor to the top-level game controller's match logic.
- Owns the match state machine, the countdown timer, the score registers and ball gating. Sits between the player and ball controllers and the display.
- Generalises the fixed 180 s / 50 MHz / 7-bit design: clock rate, duration, button count, score width and win score are configurable.
- Adds reset, a goal pause with ball re-serve, and win-by-score.

Parameters:
- CLK_HZ, 50000000, clock cycles per displayed second.
- MATCH_SECONDS, 180, initial time_left value.
- TIME_WIDTH, 8, width of time_left; must hold MATCH_SECONDS.
- NUM_BUTTONS, 8, number of active-low player buttons that can start a match.
- SCORE_WIDTH, 7, width of each score register.
- WIN_SCORE, 0, score that ends the match immediately; 0 disables win-by-score.
- GOAL_PAUSE_CYCLES, 100000000, cycles the ball is frozen after a goal; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- btn_n  in  NUM_BUTTONS  player buttons, active-low; already synchronised upstream.
- blue_goal  in  1  single-cycle pulse from the ball controller: blue scored.
- red_goal  in  1  single-cycle pulse: red scored.
- state  out  3  IDLE=0, PLAY=1, PAUSE=2, OVERTIME=3, OVER=4.
- time_left  out  TIME_WIDTH  seconds remaining.
- blue_score  out  SCORE_WIDTH  blue score.
- red_score  out  SCORE_WIDTH  red score.
- ball_enable  out  1  ball controller may move the ball.
- ball_reset  out  1  single-cycle pulse: re-serve the ball from the centre.
- game_over  out  1  high while in OVER.
- winner  out  2  0 = none/draw, 1 = blue, 2 = red; valid when game_over = 1.

Behaviour:
- Reset (async assert, sync release) values:
  - state = IDLE, time_left = MATCH_SECONDS, both scores = 0.
  - Prescaler = 0, pause counter = 0.
  - ball_enable = 0, ball_reset = 0, game_over = 0, winner = 0.
- All outputs are registered.
- IDLE:
  - Any btn_n bit low at a clock edge -> PLAY at that edge, with ball_reset = 1 for that cycle.
  - Goals are ignored.
- PLAY:
  - ball_enable = 1.
  - Prescaler counts 0..CLK_HZ-1. On wrap, time_left decrements.
  - Expiry: when the decrement takes time_left from 1 to 0, go to OVER if the scores differ. If they are tied, go to OVER with winner = 0 (see OVERTIME_EN).
- Goal in PLAY or OVERTIME:
  - The scoring team's score increments, saturating at 2^SCORE_WIDTH-1.
  - Then the win check runs: if WIN_SCORE != 0 and the new score >= WIN_SCORE, go to OVER with that team as winner.
  - Otherwise go to PAUSE.
- Simultaneous blue_goal and red_goal:
  - Both scores increment.
  - If both reach WIN_SCORE in the same cycle -> OVER with winner = 0.
  - If only one reaches it -> OVER with that team as winner.
- Goal coinciding with the final tick: apply the goal first, then evaluate expiry with the updated scores. Expiry takes precedence over PAUSE.
- PAUSE:
  - ball_enable = 0; time_left and the prescaler are frozen (values held, not cleared).
  - The pause counter runs 0..GOAL_PAUSE_CYCLES-1. On the last count, return to the pre-goal state (PLAY) with a ball_reset pulse in the same cycle.
  - Goal pulses in PAUSE are ignored.
- OVER:
  - Terminal until rst. ball_enable = 0, game_over = 1, winner held.
  - Buttons and goals are ignored.
- Reset mid-match: all state is discarded immediately, with no pulse on ball_reset.
- Width rule: scores compare unsigned; time_left never underflows below 0.

Optional Feature:
- Macro: MATCH_CONTROLLER_OVERTIME_EN.
- Defined:
  - A tie at expiry goes to OVERTIME instead of OVER, with time_left = 0 and ball_enable = 1. The prescaler is idle.
  - The first goal in OVERTIME goes straight to OVER with the scorer as winner. There is no pause.
  - A simultaneous double goal keeps the tie and stays in OVERTIME, with a ball_reset pulse.
- Undefined: the OVERTIME state is unreachable, and a tie at expiry gives OVER with winner = 0.

Test Plan:
- Bench parameters: CLK_HZ=10, MATCH_SECONDS=3, GOAL_PAUSE_CYCLES=4, WIN_SCORE=2.
- Start and countdown: after rst, drive btn_n[5]=0 for 1 cycle -> PLAY plus a ball_reset pulse. time_left reads 2, 1, 0 at 10, 20, 30 cycles. Then OVER, winner=0, game_over=1.
- Goal pause: blue_goal pulse in PLAY at prescaler=6 -> blue_score=1 and PAUSE for 4 cycles, with time_left and prescaler frozen at 6. Then PLAY with a ball_reset pulse. Further red_goal pulses during PAUSE leave red_score=0.
- Win by score: two blue goals (after the pause) -> blue_score=2, OVER with winner=1 on the second goal, no PAUSE. A later red_goal leaves red_score=0.
- Simultaneous events:
  - Blue and red goals in the same cycle at 1-1 -> both scores 2, OVER, winner=0.
  - Red goal on the final tick at 0-0 -> red_score=1, OVER, winner=2.
- Reset mid-PAUSE: assert rst asynchronously (mid-cycle) -> all outputs return to reset values before the next edge. Then a button press restarts with time_left=3.
- With MATCH_CONTROLLER_OVERTIME_EN: 0-0 at expiry -> OVERTIME, time_left=0. A red goal -> OVER, winner=2.
